// File: rtl/mac_tx_pkg.sv
// Shared definitions for the MAC transmit arbiter: state codes, grant codes,
// and the per-requester beat record that the frame mux selects from.
package mac_tx_pkg;

    localparam int NUM_REQ = 2;
    localparam int REQ_ARP = 0;
    localparam int REQ_IP  = 1;

    localparam int ST_W = 5;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 5'b00001;
    localparam state_t ST_ACK   = 5'b00010;
    localparam state_t ST_GRANT = 5'b00100;
    localparam state_t ST_DRAIN = 5'b01000;
    localparam state_t ST_GUARD = 5'b10000;

    // Grant codes are one-hot over requesters, so bit i selects requester i.
    localparam logic [NUM_REQ-1:0] GRANT_NONE = 2'b00;
    localparam logic [NUM_REQ-1:0] GRANT_ARP  = 2'b01;
    localparam logic [NUM_REQ-1:0] GRANT_IP   = 2'b10;

    typedef struct packed {
        logic       ready;
        logic [7:0] data;
        logic       last;
    } tx_beat_t;

    function automatic logic is_fwd(input state_t s);
        return (s == ST_GRANT) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Requester-side and MAC-side signals of the transmit arbiter; the arbiter
// uses the slave view, the surrounding protocol blocks and MAC the master view.
interface mac_tx_arbiter_if;
    import mac_tx_pkg::*;

    logic               arp_tx_req,  ip_tx_req;
    logic               arp_tx_ack,  ip_tx_ack;
    logic               arp_tx_ready, ip_tx_ready;
    logic [7:0]         arp_tx_data, ip_tx_data;
    logic               arp_tx_end,  ip_tx_end;
    logic               arp_mac_data_req, ip_mac_data_req;
    logic               mac_data_req;
    logic               mac_send_end;
    logic               mac_tx_ready;
    logic [7:0]         mac_tx_data;
    logic               mac_tx_end;
    logic [NUM_REQ-1:0] grant_id;

    modport master (
        output arp_tx_req, ip_tx_req, arp_tx_ready, ip_tx_ready,
               arp_tx_data, ip_tx_data, arp_tx_end, ip_tx_end,
               mac_data_req, mac_send_end,
        input  arp_tx_ack, ip_tx_ack, arp_mac_data_req, ip_mac_data_req,
               mac_tx_ready, mac_tx_data, mac_tx_end, grant_id
    );

    modport slave (
        input  arp_tx_req, ip_tx_req, arp_tx_ready, ip_tx_ready,
               arp_tx_data, ip_tx_data, arp_tx_end, ip_tx_end,
               mac_data_req, mac_send_end,
        output arp_tx_ack, ip_tx_ack, arp_mac_data_req, ip_mac_data_req,
               mac_tx_ready, mac_tx_data, mac_tx_end, grant_id
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; remembers who won last so a tie goes to
// the other requester. Starts as if IP won, so ARP takes the first tie.
module rr_arbiter2
    import mac_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_win
);

    logic [NUM_REQ-1:0] r_last;

    always_comb begin
        o_win = GRANT_NONE;
        unique case (i_req)
            2'b01:   o_win = GRANT_ARP;
            2'b10:   o_win = GRANT_IP;
            2'b11:   o_win = (r_last == GRANT_IP) ? GRANT_ARP : GRANT_IP;
            default: o_win = GRANT_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= GRANT_IP;
        else if (i_update && (o_win != GRANT_NONE))
            r_last <= o_win;
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Shares the MAC transmit path between ARP and IP senders: one grant per
// frame, held until the MAC reports the frame sent or the watchdog frees it.
module mac_tx_arbiter
    import mac_tx_pkg::*;
#(
    parameter int TIMEOUT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    mac_tx_arbiter_if.slave  bus
);

    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);
    // Firing on the cycle whose increment lands on all-ones keeps the grant
    // for exactly 2^TIMEOUT_W - 1 GRANT cycles.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~WDOG_ONE;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_seen_rdy;
    logic                 r_seen_dreq;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_win;
    tx_beat_t             w_beat [NUM_REQ];
    tx_beat_t             w_sel;
    logic                 w_enter_ack;
    logic                 w_in_grant;
    logic                 w_fwd;
    logic                 w_rdy_drop;
    logic                 w_wdog_fire;

    assign w_req[REQ_ARP]  = bus.arp_tx_req;
    assign w_req[REQ_IP]   = bus.ip_tx_req;
    assign w_beat[REQ_ARP] = {bus.arp_tx_ready, bus.arp_tx_data, bus.arp_tx_end};
    assign w_beat[REQ_IP]  = {bus.ip_tx_ready,  bus.ip_tx_data,  bus.ip_tx_end};

    assign w_enter_ack = (r_state == ST_IDLE) && (w_req != '0);
    assign w_in_grant  = (r_state == ST_GRANT);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_update (w_enter_ack),
        .o_win    (w_win)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (r_grant[i]) w_sel = w_beat[i];
    end

    // Requester abandoned the frame: ready went away before the MAC ever asked.
    assign w_rdy_drop  = r_seen_rdy && !w_sel.ready && !r_seen_dreq && !bus.mac_data_req;
    assign w_wdog_fire = !r_seen_dreq && !bus.mac_data_req && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_req != '0) w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_GRANT;
            ST_GRANT: begin
                if (w_sel.last)
                    w_state_nxt = ST_DRAIN;
                else if (w_rdy_drop || w_wdog_fire)
                    w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: if (bus.mac_send_end) w_state_nxt = ST_GUARD;
            ST_GUARD: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fwd                = is_fwd(r_state);
        bus.arp_tx_ack       = (r_state == ST_ACK) && (r_grant == GRANT_ARP);
        bus.ip_tx_ack        = (r_state == ST_ACK) && (r_grant == GRANT_IP);
        bus.mac_tx_ready     = w_fwd && w_sel.ready;
        bus.mac_tx_data      = w_fwd ? w_sel.data : 8'h00;
        bus.mac_tx_end       = w_fwd && w_sel.last;
        bus.arp_mac_data_req = w_fwd && (r_grant == GRANT_ARP) && bus.mac_data_req;
        bus.ip_mac_data_req  = w_fwd && (r_grant == GRANT_IP)  && bus.mac_data_req;
        bus.grant_id         = r_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_grant <= GRANT_NONE;
        else if (w_enter_ack)
            r_grant <= w_win;
        else if (w_state_nxt == ST_IDLE)
            r_grant <= GRANT_NONE;
    end

    // Once the MAC has asked for bytes the frame may be arbitrarily long, so
    // the watchdog parks at zero for the rest of the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog      <= '0;
            r_seen_rdy  <= 1'b0;
            r_seen_dreq <= 1'b0;
        end else if (!w_in_grant) begin
            r_wdog      <= '0;
            r_seen_rdy  <= 1'b0;
            r_seen_dreq <= 1'b0;
        end else begin
            if (w_sel.ready)
                r_seen_rdy <= 1'b1;
            if (bus.mac_data_req) begin
                r_seen_dreq <= 1'b1;
                r_wdog      <= '0;
            end else if (!r_seen_dreq) begin
                r_wdog      <= r_wdog + WDOG_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed scenarios for the MAC transmit arbiter, checked every cycle against
// a frame-level model plus a few hand-derived cycle/value expectations.
module tb_mac_tx_arbiter;

    localparam int TW    = 4;
    localparam int WD_CY = (1 << TW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ACK   = 1;
    localparam int P_GRANT = 2;
    localparam int P_DRAIN = 3;
    localparam int P_GUARD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_tx_arbiter_if bus_if();

    mac_tx_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc - base, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_owner, m_last, m_gcnt;
    bit m_srdy, m_sdreq;

    function automatic int m_pick();
        if (bus_if.arp_tx_req && bus_if.ip_tx_req) return (m_last == 2) ? 1 : 2;
        return bus_if.arp_tx_req ? 1 : 2;
    endfunction

    function automatic logic own_rdy();
        if (m_owner == 1) return bus_if.arp_tx_ready;
        if (m_owner == 2) return bus_if.ip_tx_ready;
        return 1'b0;
    endfunction

    function automatic logic own_end();
        if (m_owner == 1) return bus_if.arp_tx_end;
        if (m_owner == 2) return bus_if.ip_tx_end;
        return 1'b0;
    endfunction

    function automatic logic [7:0] own_data();
        if (m_owner == 1) return bus_if.arp_tx_data;
        if (m_owner == 2) return bus_if.ip_tx_data;
        return 8'h00;
    endfunction

    function automatic bit fwd();
        return (m_phase == P_GRANT) || (m_phase == P_DRAIN);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE; m_owner <= 0; m_last <= 2;
            m_gcnt  <= 0; m_srdy <= 1'b0; m_sdreq <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (bus_if.arp_tx_req || bus_if.ip_tx_req) begin
                    m_owner <= m_pick();
                    m_last  <= m_pick();
                    m_phase <= P_ACK;
                end
                P_ACK: begin
                    m_phase <= P_GRANT; m_gcnt <= 0; m_srdy <= 1'b0; m_sdreq <= 1'b0;
                end
                P_GRANT: begin
                    m_gcnt  <= m_gcnt + 1;
                    m_srdy  <= m_srdy | own_rdy();
                    m_sdreq <= m_sdreq | bus_if.mac_data_req;
                    if (own_end())
                        m_phase <= P_DRAIN;
                    else if (!m_sdreq && !bus_if.mac_data_req &&
                             ((m_srdy && !own_rdy()) || (m_gcnt + 1 == WD_CY))) begin
                        m_phase <= P_IDLE; m_owner <= 0;
                    end
                end
                P_DRAIN: if (bus_if.mac_send_end) m_phase <= P_GUARD;
                default: begin m_phase <= P_IDLE; m_owner <= 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("arp_ack",   32'(bus_if.arp_tx_ack),   32'(m_phase == P_ACK && m_owner == 1));
            chk("ip_ack",    32'(bus_if.ip_tx_ack),    32'(m_phase == P_ACK && m_owner == 2));
            chk("grant_id",  32'(bus_if.grant_id),     32'(m_owner));
            chk("tx_ready",  32'(bus_if.mac_tx_ready), 32'(fwd() && own_rdy()));
            chk("tx_data",   32'(bus_if.mac_tx_data),  32'(fwd() ? own_data() : 8'h00));
            chk("tx_end",    32'(bus_if.mac_tx_end),   32'(fwd() && own_end()));
            chk("arp_dreq",  32'(bus_if.arp_mac_data_req), 32'(fwd() && m_owner == 1 && bus_if.mac_data_req));
            chk("ip_dreq",   32'(bus_if.ip_mac_data_req),  32'(fwd() && m_owner == 2 && bus_if.mac_data_req));
        end
    end

    // ---------------- stimulus ----------------
    task automatic at(input int c);
        while (cyc < base + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_inputs();
        bus_if.arp_tx_req = 0; bus_if.ip_tx_req = 0;
        bus_if.arp_tx_ready = 0; bus_if.ip_tx_ready = 0;
        bus_if.arp_tx_data = 0; bus_if.ip_tx_data = 0;
        bus_if.arp_tx_end = 0; bus_if.ip_tx_end = 0;
        bus_if.mac_data_req = 0; bus_if.mac_send_end = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        clr_inputs();
        do_reset();
        chk_en = 1'b1;
        chk("rst_grant_id", 32'(bus_if.grant_id), 32'h0);
        chk("rst_tx_ready", 32'(bus_if.mac_tx_ready), 32'h0);

        // ARP alone, 60-byte frame; IP has data staged but never requests
        at(1);  bus_if.ip_tx_ready = 1; bus_if.ip_tx_data = 8'hEE;
        at(10); chk("s1_ack_c10", 32'(bus_if.arp_tx_ack), 32'h0);
                bus_if.arp_tx_req = 1;
        at(11); chk("s1_ack_c11", 32'(bus_if.arp_tx_ack), 32'h1);
                bus_if.arp_tx_req = 0;
        at(12); chk("s1_ack_c12", 32'(bus_if.arp_tx_ack), 32'h0);
                bus_if.arp_tx_ready = 1; bus_if.arp_tx_data = 8'h3F;
        at(13); bus_if.mac_data_req = 1;
        for (int i = 0; i < 60; i++) begin
            at(14 + i);
            bus_if.arp_tx_data  = 8'(8'h40 + i);
            bus_if.arp_tx_end   = (i == 59);
            bus_if.mac_data_req = (i % 10 == 5);
            bus_if.mac_send_end = (i == 30);
            if (i == 59) begin
                #1;
                chk("s1_last_byte", 32'(bus_if.mac_tx_data), 32'h7B);
                chk("s1_last_end",  32'(bus_if.mac_tx_end),  32'h1);
            end
        end
        at(74); bus_if.arp_tx_end = 0; bus_if.arp_tx_ready = 0; bus_if.arp_tx_data = 0;
                bus_if.mac_data_req = 0;
        at(90); bus_if.mac_send_end = 1;
        at(91); bus_if.mac_send_end = 0;
                chk("s1_guard_gid", 32'(bus_if.grant_id), 32'h1);
        at(92); chk("s1_idle_gid",  32'(bus_if.grant_id), 32'h0);

        // Tie after reset: ARP first, then IP wins the next tie
        do_reset();
        at(5);  bus_if.arp_tx_req = 1; bus_if.ip_tx_req = 1;
        at(6);  chk("s2_arp_first", 32'(bus_if.arp_tx_ack), 32'h1);
                chk("s2_ip_wait",   32'(bus_if.ip_tx_ack),  32'h0);
                bus_if.arp_tx_req = 0;
        at(7);  bus_if.arp_tx_ready = 1; bus_if.arp_tx_data = 8'h11;
        at(8);  bus_if.mac_data_req = 1;
        at(9);  bus_if.mac_data_req = 0; bus_if.arp_tx_data = 8'h12; bus_if.arp_tx_end = 1;
        at(10); bus_if.arp_tx_end = 0; bus_if.arp_tx_ready = 0;
        at(12); bus_if.mac_send_end = 1;
        at(13); bus_if.mac_send_end = 0; bus_if.arp_tx_req = 1;
        at(14); chk("s2_ip_c14", 32'(bus_if.ip_tx_ack), 32'h0);
        at(15); chk("s2_ip_c15", 32'(bus_if.ip_tx_ack), 32'h1);
                chk("s2_gid_ip", 32'(bus_if.grant_id),  32'h2);
                bus_if.ip_tx_req = 0;
        at(16); bus_if.ip_tx_ready = 1; bus_if.ip_tx_data = 8'h21;
        at(17); bus_if.mac_data_req = 1;
        at(18); bus_if.mac_data_req = 0; bus_if.ip_tx_data = 8'h22; bus_if.ip_tx_end = 1;
        at(19); bus_if.ip_tx_end = 0; bus_if.ip_tx_ready = 0; bus_if.mac_send_end = 1;
        at(20); bus_if.mac_send_end = 0;
        at(22); chk("s2_arp_again", 32'(bus_if.arp_tx_ack), 32'h1);
                bus_if.arp_tx_req = 0;

        // ARP gives up (ready high then low, no data req); IP then times out
        do_reset();
        at(3);  bus_if.arp_tx_req = 1;
        at(4);  bus_if.arp_tx_req = 0; bus_if.ip_tx_req = 1;
        at(5);  bus_if.arp_tx_ready = 1;
        at(7);  bus_if.arp_tx_ready = 0;
        at(8);  chk("s3_idle_gid", 32'(bus_if.grant_id),  32'h0);
                chk("s3_ip_c8",    32'(bus_if.ip_tx_ack), 32'h0);
        at(9);  chk("s3_ip_c9",    32'(bus_if.ip_tx_ack), 32'h1);
                bus_if.ip_tx_req = 0;
        at(24); chk("s4_wd_c24", 32'(bus_if.grant_id), 32'h2);
        at(25); chk("s4_wd_c25", 32'(bus_if.grant_id), 32'h0);

        // Reset in the middle of an IP frame, then a fresh ARP grant
        do_reset();
        at(2);  bus_if.ip_tx_req = 1;
        at(3);  bus_if.ip_tx_req = 0;
        at(4);  bus_if.ip_tx_ready = 1; bus_if.ip_tx_data = 8'h7F;
        at(5);  bus_if.mac_data_req = 1;
        for (int i = 0; i <= 20; i++) begin
            at(6 + i);
            bus_if.mac_data_req = 0;
            bus_if.ip_tx_data   = 8'(8'h80 + i);
        end
        #1;
        chk("s5_byte20", 32'(bus_if.mac_tx_data), 32'h94);
        bus_if.mac_data_req = 1;
        #1;
        chk("s5_dreq_pre", 32'(bus_if.ip_mac_data_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_ready", 32'(bus_if.mac_tx_ready),    32'h0);
        chk("s5_rst_data",  32'(bus_if.mac_tx_data),     32'h0);
        chk("s5_rst_gid",   32'(bus_if.grant_id),        32'h0);
        chk("s5_rst_dreq",  32'(bus_if.ip_mac_data_req), 32'h0);
        do_reset();
        at(2);  bus_if.arp_tx_req = 1;
        at(3);  chk("s5_arp_ack", 32'(bus_if.arp_tx_ack), 32'h1);
                chk("s5_arp_gid", 32'(bus_if.grant_id),   32'h1);
                bus_if.arp_tx_req = 0;
        at(4);  chk("s5_arp_ack_off", 32'(bus_if.arp_tx_ack), 32'h0);
        at(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
